// File: rtl/uart_io_buffer_if.sv
// Core-side and UART-side byte handshakes of uart_io_buffer.
// slave: the buffer itself; master: core plus UART byte engine driving it.
interface uart_io_buffer_if;
    logic       send_en;
    logic [7:0] send_data;
    logic       send_ready;
    logic       recv_req;
    logic       recv_valid;
    logic [7:0] recv_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_overrun;

    modport master (
        output send_en, send_data, recv_req, tx_busy, rx_valid, rx_data,
        input  send_ready, recv_valid, recv_data, tx_start, tx_data, rx_overrun
    );

    modport slave (
        input  send_en, send_data, recv_req, tx_busy, rx_valid, rx_data,
        output send_ready, recv_valid, recv_data, tx_start, tx_data, rx_overrun
    );
endinterface

// File: rtl/uart_io_buffer.sv
// TX/RX byte FIFOs between the core io_send/io_recv ports and a byte-level UART.
// Define UART_IO_LOOPBACK_EN to add the loopback input (TX bytes routed into RX FIFO).
module uart_io_buffer #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 64
) (
    input  logic            clock,
    input  logic            reset,
`ifdef UART_IO_LOOPBACK_EN
    input  logic            loopback,
`endif
    uart_io_buffer_if.slave io
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT
    } tx_state_e;

    // TX FIFO and pacing state
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
    logic [TX_AW:0]   tx_cnt_q;
    logic [7:0]       tx_data_q;
    tx_state_e        tx_state_q, tx_state_d;
    logic             tx_full, tx_empty, tx_push, tx_pop, tx_start_c, lb_wr;

    // RX FIFO and receive handshake state
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
    logic [RX_AW:0]   rx_cnt_q;
    logic             recv_valid_q, rx_overrun_q;
    logic [7:0]       recv_data_q;
    logic             rx_full, rx_empty, rx_push, rx_pop, rx_in_valid;
    logic [7:0]       rx_in_data;

    logic             lb_active;

`ifdef UART_IO_LOOPBACK_EN
    assign lb_active = loopback;
`else
    assign lb_active = 1'b0;
`endif

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = io.send_en & ~tx_full;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_pop     = 1'b0;
        tx_start_c = 1'b0;
        lb_wr      = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                // Loopback bytes skip the transmitter and land in the RX FIFO.
                if (lb_active) begin
                    lb_wr      = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_start_c = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!io.tx_busy) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_push) begin
                tx_wptr_q <= tx_wptr_q + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr_q <= tx_rptr_q + 1'b1;
                tx_data_q <= tx_mem_q[tx_rptr_q];
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= io.send_data;
        end
    end

    assign rx_full     = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty    = (rx_cnt_q == '0);
    assign rx_in_valid = lb_active ? lb_wr : io.rx_valid;
    assign rx_in_data  = lb_active ? tx_data_q : io.rx_data;
    assign rx_pop      = io.recv_req & ~rx_empty & ~recv_valid_q;
    // A same-cycle pop frees the slot, so a write into a full FIFO is still accepted.
    assign rx_push     = rx_in_valid & (~rx_full | rx_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            rx_cnt_q     <= '0;
            recv_valid_q <= 1'b0;
            recv_data_q  <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            recv_valid_q <= rx_pop;
            if (rx_push) begin
                rx_wptr_q <= rx_wptr_q + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr_q   <= rx_rptr_q + 1'b1;
                recv_data_q <= rx_mem_q[rx_rptr_q];
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
            if (rx_in_valid && rx_full && !rx_pop) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= rx_in_data;
        end
    end

    assign io.send_ready = ~tx_full;
    assign io.tx_start   = tx_start_c;
    assign io.tx_data    = tx_data_q;
    assign io.recv_valid = recv_valid_q;
    assign io.recv_data  = recv_data_q;
    assign io.rx_overrun = rx_overrun_q;

endmodule
